// File: rtl/ccip_tx_flow_scheduler_pkg.sv
// Shared types for the CCI-P transmit flow scheduler: FSM states, burst-length
// encodings and the batch-size helpers.
package nic_defs;

  localparam int LMAX_CCIP_BATCH = 2;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [1:0] {
    SchedScan,
    SchedIssue,
    SchedSettle
  } SchedState;

  // Batch sizes above four lines are not legal on c1, so they fold onto four.
  function automatic logic [1:0] clamp_l_batch(input logic [LMAX_CCIP_BATCH-1:0] l_batch);
    return (l_batch > 2'd2) ? 2'd2 : l_batch;
  endfunction

  function automatic t_ccip_clLen batch_to_cl_len(input logic [1:0] l_len);
    case (l_len)
      2'd0:    return eCL_LEN_1;
      2'd1:    return eCL_LEN_2;
      default: return eCL_LEN_4;
    endcase
  endfunction

endpackage

// File: rtl/ccip_tx_flow_scheduler_if.sv
// Flow-FIFO side of the scheduler: fill levels and c1 back-pressure in,
// pop strobes and burst framing out.
interface ccip_tx_flow_scheduler_if #(
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LFIFO_DEPTH       = 3
);
  localparam int MAX_FLOWS = 2 ** LMAX_NUM_OF_FLOWS;

  logic                               c1_alm_full;
  logic [MAX_FLOWS*LFIFO_DEPTH-1:0]   ff_dw_in;
  logic [MAX_FLOWS-1:0]               ff_pop_en_out;
  logic [LMAX_NUM_OF_FLOWS-1:0]       pop_flow_out;
  logic                               batch_start_out;
  logic                               batch_last_out;
  logic [1:0]                         batch_cl_len_out;

  modport master (
    input  c1_alm_full,
    input  ff_dw_in,
    output ff_pop_en_out,
    output pop_flow_out,
    output batch_start_out,
    output batch_last_out,
    output batch_cl_len_out
  );

  modport slave (
    output c1_alm_full,
    output ff_dw_in,
    input  ff_pop_en_out,
    input  pop_flow_out,
    input  batch_start_out,
    input  batch_last_out,
    input  batch_cl_len_out
  );

endinterface

// File: rtl/ccip_tx_flow_scheduler_age_counter.sv
// Per-flow age counter: counts cycles a flow has waited with data pending,
// frozen while the flow is being popped and saturating at all-ones.
module tx_flow_age_counter #(
  parameter int LTIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                nonempty,
  input  logic                clear,
  input  logic                hold,
  output logic [LTIMEOUT-1:0] age
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      age <= '0;
    end else if (!nonempty || clear) begin
      age <= '0;
    end else if (!hold && (age != '1)) begin
      age <= age + 1'b1;
    end
  end

endmodule

// File: rtl/ccip_tx_flow_scheduler.sv
// Round-robin pop-burst scheduler for the CPU-bound transmit flows: grants a
// full CCI-P batch, or a partial batch once a flow has aged past the flush timeout.
//
// state       | meaning
// SchedScan   | examine flow at the pointer each cycle, grant or advance
// SchedIssue  | one pop per cycle to the latched flow until the burst ends
// SchedSettle | idle so FIFO fill levels catch up with the pops
module ccip_tx_flow_scheduler
  import nic_defs::*;
#(
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LFIFO_DEPTH       = 3,
  parameter int LTIMEOUT          = 16,
  parameter int SETTLE_CYCLES     = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [LMAX_NUM_OF_FLOWS-1:0]  number_of_flows,
  input  logic [LMAX_CCIP_BATCH-1:0]    l_tx_batch_size,
  input  logic [LTIMEOUT-1:0]           flush_timeout,
  ccip_tx_flow_scheduler_if.master      fifo,
  output logic                          busy_out,
  output logic [31:0]                   flush_cnt_out
);

  localparam int MAX_FLOWS = 2 ** LMAX_NUM_OF_FLOWS;
  localparam int DW_W      = (LFIFO_DEPTH > 3) ? LFIFO_DEPTH : 3;
  localparam int SETTLE_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SETTLE_TC = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  typedef logic [LMAX_NUM_OF_FLOWS-1:0] FlowId;

  function automatic FlowId advance_ptr(input FlowId p, input FlowId last_flow);
    return (p >= last_flow) ? '0 : FlowId'(p + 1'b1);
  endfunction

  SchedState            state_q, state_d;
  FlowId                ptr_q, ptr_d;
  FlowId                flow_q, flow_d;
  FlowId                nflows_q, nflows_d;
  logic [1:0]           l_len_q, l_len_d;
  logic [1:0]           pop_idx_q, pop_idx_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic [31:0]          flush_cnt_q, flush_cnt_d;
  t_ccip_clLen          cl_len_q, cl_len_d;

  logic [LFIFO_DEPTH-1:0] dw  [MAX_FLOWS];
  logic [LTIMEOUT-1:0]    age [MAX_FLOWS];
  logic [MAX_FLOWS-1:0]   age_clear;
  logic [MAX_FLOWS-1:0]   age_hold;

  logic                 in_issue;
  logic                 grant;
  logic                 full_ok;
  logic                 flush_ok;
  logic                 can_grant;
  logic [1:0]           l_eff;
  logic [2:0]           batch_lines;
  logic [DW_W-1:0]      dw_p;
  logic [LTIMEOUT-1:0]  age_p;
  logic [1:0]           flush_l_len;
  logic [1:0]           grant_l_len;
  logic [1:0]           pop_last_idx;
  logic                 pop_last;

  assign in_issue = (state_q == SchedIssue);

  for (genvar i = 0; i < MAX_FLOWS; i++) begin : g_flow
    assign dw[i]        = fifo.ff_dw_in[i*LFIFO_DEPTH +: LFIFO_DEPTH];
    assign age_hold[i]  = in_issue && (flow_q == FlowId'(i));
    assign age_clear[i] = grant && (ptr_q == FlowId'(i));

    tx_flow_age_counter #(
      .LTIMEOUT (LTIMEOUT)
    ) u_age (
      .clk      (clk),
      .reset    (reset),
      .nonempty (dw[i] != '0),
      .clear    (age_clear[i]),
      .hold     (age_hold[i]),
      .age      (age[i])
    );
  end

  // Grant decode for the flow under the pointer; a pointer left above a
  // reduced number_of_flows never grants, it only wraps.
  always_comb begin
    l_eff       = clamp_l_batch(l_tx_batch_size);
    batch_lines = 3'b001 << l_eff;
    dw_p        = DW_W'(dw[ptr_q]);
    age_p       = age[ptr_q];
    can_grant   = (state_q == SchedScan) && start && !fifo.c1_alm_full &&
                  (ptr_q <= number_of_flows);
    full_ok     = can_grant && (dw_p >= DW_W'(batch_lines));
    flush_ok    = can_grant && (flush_timeout != '0) && (dw_p != '0) &&
                  (dw_p < DW_W'(batch_lines)) && (age_p >= flush_timeout);
    // A partial batch is below four lines, so its largest power of two is 1 or 2.
    flush_l_len = dw_p[1] ? 2'd1 : 2'd0;
    grant_l_len = full_ok ? l_eff : flush_l_len;
    grant       = full_ok || flush_ok;
  end

  always_comb begin
    case (l_len_q)
      2'd0:    pop_last_idx = 2'd0;
      2'd1:    pop_last_idx = 2'd1;
      default: pop_last_idx = 2'd3;
    endcase
    pop_last = in_issue && (pop_idx_q == pop_last_idx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SchedScan;
      ptr_q       <= '0;
      flow_q      <= '0;
      nflows_q    <= '0;
      l_len_q     <= '0;
      pop_idx_q   <= '0;
      settle_q    <= '0;
      flush_cnt_q <= '0;
      cl_len_q    <= eCL_LEN_1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      flow_q      <= flow_d;
      nflows_q    <= nflows_d;
      l_len_q     <= l_len_d;
      pop_idx_q   <= pop_idx_d;
      settle_q    <= settle_d;
      flush_cnt_q <= flush_cnt_d;
      cl_len_q    <= cl_len_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    flow_d      = flow_q;
    nflows_d    = nflows_q;
    l_len_d     = l_len_q;
    pop_idx_d   = pop_idx_q;
    settle_d    = settle_q;
    flush_cnt_d = flush_cnt_q;
    cl_len_d    = cl_len_q;

    case (state_q)
      SchedScan: begin
        if (grant) begin
          state_d   = SchedIssue;
          flow_d    = ptr_q;
          nflows_d  = number_of_flows;
          l_len_d   = grant_l_len;
          cl_len_d  = batch_to_cl_len(grant_l_len);
          pop_idx_d = '0;
          if (!full_ok && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
          end
        end else if (!fifo.c1_alm_full) begin
          ptr_d = advance_ptr(ptr_q, number_of_flows);
        end
      end

      SchedIssue: begin
        if (pop_last) begin
          // Flow count latched at grant, so mid-burst config changes stay out.
          ptr_d    = advance_ptr(ptr_q, nflows_q);
          settle_d = SETTLE_W'(SETTLE_TC);
          state_d  = (SETTLE_CYCLES > 0) ? SchedSettle : SchedScan;
        end else begin
          pop_idx_d = pop_idx_q + 2'd1;
        end
      end

      SchedSettle: begin
        if (settle_q == '0) begin
          state_d = SchedScan;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end

      default: state_d = SchedScan;
    endcase
  end

  // Pop outputs decode straight from the state register so reset kills a
  // burst in the same cycle.
  assign fifo.ff_pop_en_out    = in_issue ? (MAX_FLOWS'(1) << flow_q) : '0;
  assign fifo.pop_flow_out     = flow_q;
  assign fifo.batch_start_out  = in_issue && (pop_idx_q == 2'd0);
  assign fifo.batch_last_out   = pop_last;
  assign fifo.batch_cl_len_out = cl_len_q;
  assign busy_out              = (state_q != SchedScan);
  assign flush_cnt_out         = flush_cnt_q;

endmodule

// File: tb/tb_ccip_tx_flow_scheduler.sv
// Self-checking bench for ccip_tx_flow_scheduler: directed scenarios plus a
// randomized run, all against a timestamp-based grant model.
module tb_ccip_tx_flow_scheduler;
  import nic_defs::*;

  localparam int LMAX   = 2;
  localparam int NF     = 4;
  localparam int LFD    = 3;
  localparam int LTO    = 16;
  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  number_of_flows;
  logic [1:0]  l_tx_batch_size;
  logic [15:0] flush_timeout;
  logic        busy_out;
  logic [31:0] flush_cnt_out;
  logic        alm;
  logic [2:0]  dw_arr [NF];

  ccip_tx_flow_scheduler_if #(.LMAX_NUM_OF_FLOWS(LMAX), .LFIFO_DEPTH(LFD)) fifo ();

  ccip_tx_flow_scheduler #(
    .LMAX_NUM_OF_FLOWS (LMAX),
    .LFIFO_DEPTH       (LFD),
    .LTIMEOUT          (LTO),
    .SETTLE_CYCLES     (SETTLE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .number_of_flows (number_of_flows),
    .l_tx_batch_size (l_tx_batch_size),
    .flush_timeout   (flush_timeout),
    .fifo            (fifo),
    .busy_out        (busy_out),
    .flush_cnt_out   (flush_cnt_out)
  );

  always #5 clk = ~clk;

  assign fifo.c1_alm_full = alm;
  always_comb begin
    fifo.ff_dw_in = '0;
    for (int i = 0; i < NF; i++) fifo.ff_dw_in[i*LFD +: LFD] = dw_arr[i];
  end

  int errors = 0;
  int checks = 0;

  // Reference model: each grant is a timestamp plus a length; the burst occupies
  // the len cycles after the grant and scanning resumes SETTLE cycles later.
  int          t;
  int          m_ptr;
  int          m_age [NF];
  int          g_start, g_len, g_flow, m_cl, scan_from;
  logic [31:0] m_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < NF; i++) m_age[i] = 0;
    g_start   = t - 1;
    g_len     = 0;
    g_flow    = 0;
    m_cl      = 0;
    scan_from = t;
    m_flush   = '0;
  endtask

  task automatic model_advance();
    int  nf, lb, b, p, len;
    bit  grant, flush, held;
    nf    = int'(number_of_flows);
    lb    = (l_tx_batch_size > 2) ? 2 : int'(l_tx_batch_size);
    b     = 1 << lb;
    p     = m_ptr;
    grant = 0;
    flush = 0;
    len   = 0;
    if (t >= scan_from && start && !alm && p <= nf) begin
      if (int'(dw_arr[p]) >= b) begin
        grant = 1;
        len   = b;
      end else if (flush_timeout != 0 && dw_arr[p] != 0 && m_age[p] >= int'(flush_timeout)) begin
        grant = 1;
        flush = 1;
        len   = (dw_arr[p] >= 2) ? 2 : 1;
      end
    end
    for (int i = 0; i < NF; i++) begin
      held = (i == g_flow) && (t > g_start) && (t <= g_start + g_len);
      if (dw_arr[i] == 0 || (grant && i == p)) m_age[i] = 0;
      else if (!held && m_age[i] < (1 << LTO) - 1) m_age[i]++;
    end
    if (grant) begin
      g_start   = t;
      g_len     = len;
      g_flow    = p;
      m_cl      = (len == 1) ? 0 : (len == 2) ? 1 : 3;
      scan_from = t + len + 1 + SETTLE;
      m_ptr     = (p >= nf) ? 0 : p + 1;
      if (flush && m_flush != 32'hFFFF_FFFF) m_flush++;
    end else if (t >= scan_from && !alm) begin
      m_ptr = (p >= nf) ? 0 : p + 1;
    end
    t++;
  endtask

  task automatic check_outputs();
    bit in_b;
    in_b = (t > g_start) && (t <= g_start + g_len);
    chk("pop_en",      fifo.ff_pop_en_out, in_b ? (32'd1 << g_flow) : 32'd0);
    chk("batch_start", fifo.batch_start_out, in_b && (t == g_start + 1));
    chk("batch_last",  fifo.batch_last_out, in_b && (t == g_start + g_len));
    chk("pop_flow",    fifo.pop_flow_out, g_flow);
    chk("cl_len",      fifo.batch_cl_len_out, m_cl);
    chk("busy",        busy_out, (t > g_start) && (t < scan_from));
    chk("flush_cnt",   flush_cnt_out, m_flush);
  endtask

  task automatic tick();
    model_advance();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_burst(input int bound, output bit done, output int pops,
                           output int flow, output int cl, output int ts, output int tl);
    done = 0; pops = 0; flow = -1; cl = -1; ts = -1; tl = -1;
    for (int i = 0; i < bound && !done; i++) begin
      tick();
      if (fifo.ff_pop_en_out != 0) pops++;
      if (fifo.batch_start_out === 1'b1) begin
        flow = int'(fifo.pop_flow_out);
        cl   = int'(fifo.batch_cl_len_out);
        ts   = t;
      end
      if (fifo.batch_last_out === 1'b1) begin
        done = 1;
        tl   = t;
      end
    end
  endtask

  task automatic drain();
    int n;
    start = 1'b0;
    alm   = 1'b0;
    for (int i = 0; i < NF; i++) dw_arr[i] = '0;
    n = 0;
    while (busy_out !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_idle", busy_out, 1'b0);
    tick();
  endtask

  initial begin
    bit done;
    int pops, flow, cl, ts, tl, t0, hi_pops, first_flow;
    int flows [4];
    int lasts [4];
    int starts [4];

    t = 0;
    reset = 1'b1; start = 1'b0; number_of_flows = 2'd0; l_tx_batch_size = 2'd0;
    flush_timeout = 16'd0; alm = 1'b0;
    for (int i = 0; i < NF; i++) dw_arr[i] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // Two-line batch on flow 1 of two flows.
    number_of_flows = 2'd1; l_tx_batch_size = 2'd1; start = 1'b1;
    dw_arr[1] = 3'd3;
    run_burst(20, done, pops, flow, cl, ts, tl);
    chk("t1_done", done, 1'b1);
    chk("t1_pops", pops, 2);
    chk("t1_flow", flow, 1);
    chk("t1_cl_len", cl, eCL_LEN_2);
    drain();

    // Partial batch flushed once flow 0 has aged to the timeout.
    l_tx_batch_size = 2'd2; flush_timeout = 16'd10; start = 1'b1;
    dw_arr[0] = 3'd3;
    t0 = t;
    run_burst(40, done, pops, flow, cl, ts, tl);
    chk("t2_done", done, 1'b1);
    chk("t2_pops", pops, 2);
    chk("t2_flow", flow, 0);
    chk("t2_cl_len", cl, eCL_LEN_2);
    chk("t2_latency_ok", (ts - t0 >= 11) && (ts - t0 <= 12), 1'b1);
    chk("t2_flush_cnt", flush_cnt_out, 32'd1);
    drain();

    // Two always-ready flows alternate with a settle gap.
    flush_timeout = 16'd0; l_tx_batch_size = 2'd1; start = 1'b1;
    dw_arr[0] = 3'd5; dw_arr[1] = 3'd5;
    for (int k = 0; k < 4; k++) begin
      run_burst(20, done, pops, flow, cl, ts, tl);
      chk("t3_done", done, 1'b1);
      chk("t3_pops", pops, 2);
      flows[k] = flow; starts[k] = ts; lasts[k] = tl;
    end
    for (int k = 1; k < 4; k++) begin
      chk("t3_alternate", flows[k] != flows[k-1], 1'b1);
      chk("t3_gap", starts[k] - lasts[k-1], SETTLE + 2);
    end
    drain();

    // alm_full raised during a four-line burst.
    l_tx_batch_size = 2'd2; start = 1'b1; dw_arr[0] = 3'd7;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (fifo.batch_start_out === 1'b1) done = 1;
    end
    chk("t4_started", done, 1'b1);
    alm = 1'b1;
    pops = 1; done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (fifo.ff_pop_en_out != 0) pops++;
      if (fifo.batch_last_out === 1'b1) done = 1;
    end
    chk("t4_pops", pops, 4);
    pops = 0;
    repeat (8) begin
      tick();
      if (fifo.ff_pop_en_out != 0) pops++;
    end
    chk("t4_held_off", pops, 0);
    alm = 1'b0;
    run_burst(20, done, pops, flow, cl, ts, tl);
    chk("t4_resumed", done, 1'b1);
    drain();

    // Reset asserted on the second pop of a burst.
    l_tx_batch_size = 2'd2; start = 1'b1; dw_arr[0] = 3'd7; dw_arr[1] = 3'd7;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (fifo.batch_start_out === 1'b1) done = 1;
    end
    chk("t5_started", done, 1'b1);
    tick();
    reset = 1'b1;
    #1;
    chk("t5_pop_async", fifo.ff_pop_en_out, 4'd0);
    chk("t5_busy_async", busy_out, 1'b0);
    @(negedge clk);
    t++;
    model_reset();
    reset = 1'b0;
    check_outputs();
    chk("t5_flush_cnt", flush_cnt_out, 32'd0);
    tick();
    chk("t5_ptr0_grant", fifo.ff_pop_en_out, 4'b0001);
    drain();

    // number_of_flows shrinks while the pointer sits on flow 3.
    number_of_flows = 2'd3; l_tx_batch_size = 2'd0; start = 1'b0;
    for (int i = 0; i < 12 && m_ptr != 3; i++) tick();
    chk("t6_ptr_at_3", m_ptr, 3);
    number_of_flows = 2'd1; start = 1'b1;
    for (int i = 0; i < NF; i++) dw_arr[i] = 3'd2;
    hi_pops = 0; first_flow = -1;
    repeat (40) begin
      tick();
      if (fifo.ff_pop_en_out[3:2] != 2'b00) hi_pops++;
      if (first_flow < 0 && fifo.batch_start_out === 1'b1) first_flow = int'(fifo.pop_flow_out);
    end
    chk("t6_first_flow", first_flow, 0);
    chk("t6_no_high_flows", hi_pops, 0);
    drain();

    // Randomized traffic and configuration.
    start = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0)  start = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 5) == 0)  alm = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 31) == 0) number_of_flows = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) l_tx_batch_size = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0)
        flush_timeout = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      for (int i = 0; i < NF; i++)
        if ($urandom_range(0, 9) == 0) dw_arr[i] = 3'($urandom_range(0, 7));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
